regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the single write port of the 32x32 register file (r0 hard-wired zero) between N requesters.
//   Round-robin arbitration with a per-requester valid/ready handshake; the winner is staged into
//   a registered write stage that drives the regfile write port one cycle later.
//   Also exports a mask of the register being written, which read-side logic uses to stall.
// PARAMETERS
//   N       4   number of write requesters (2..8)
//   AW      5   register address width (32 registers)
//   DW      32  register data width
// PORTS
//   clk           in   1      clock; all state updates on rising edge
//   rst_n         in   1      asynchronous, active-low reset
//   req_valid     in   N      requester i has a write pending
//   req_addr      in   N*AW   target register of requester i; slice [i*AW +: AW]
//   req_data      in   N*DW   write data of requester i; slice [i*DW +: DW]
//   req_ready     out  N      one-hot (or zero) grant; transfer = valid & ready at rising edge
//   wr_stall      in   1      when high, no grants are issued this cycle
//   wr_enable     out  1      regfile write enable
//   wr_addr       out  AW     regfile write register
//   wr_data       out  DW     regfile write data
//   pending_mask  out  32     bit a high while the staged write targets register a
//   dropped_zero  out  1      1-cycle pulse: an accepted write to r0 was discarded
// BEHAVIOUR
//   - Reset (rst_n low, async): rr_ptr=0, wr_enable=0, wr_addr=0, wr_data=0, dropped_zero=0.
//     req_ready=0 and pending_mask=0 while reset is asserted. Deassertion needs no settling cycle.
//   - Grant (combinational, same cycle):
//     - if wr_stall=1 or no valid is high, req_ready=0.
//     - else req_ready[i]=1 for the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
//     - req_ready never depends on ready of any other block; at most one bit set.
//   - Requester rule: once raised, valid/addr/data stay stable until the transfer edge.
//     The bench flags a violation; the RTL does not check it.
//   - Round-robin pointer: on a transfer from i, rr_ptr <= (i+1) mod N; no transfer -> unchanged.
//     The pointer is log2 width and wraps at N, not at a power of two.
//   - Write stage: on a transfer at edge k, the following happens from edge k until edge k+1:
//     - if addr!=0: wr_enable=1, wr_addr=addr, wr_data=data.
//     - if addr==0: wr_enable=0, dropped_zero=1, wr_addr and wr_data loaded anyway.
//     The regfile therefore writes at edge k+1, a fixed latency of 1 cycle.
//     With no transfer at edge k: wr_enable=0, dropped_zero=0, wr_addr and wr_data hold.
//   - Throughput: one write per cycle sustained; back-to-back transfers from different requesters are legal.
//   - pending_mask = wr_enable ? (1<<wr_addr) : 0 (combinational from the stage registers).
//   - Stall: wr_stall only blocks new grants; an already-staged write still completes at the next edge.
//   - Mid-operation reset: the staged write is discarded (wr_enable=0 immediately, asynchronously) and no regfile write occurs.
//     Requesters re-present after reset.
//   - Simultaneous valids: exactly one is served per cycle; the others keep ready=0 and must hold.
//     Worst-case wait for any requester is N-1 cycles without stall.
// STRUCTURE
//   - Shared include regfile_defs.vh: REG_AW=5, REG_DW=32, NUM_REGS=32, REG_ZERO=0.
//     Used by the regfile and by this block.
//   - Sub-module rr_priority_picker #(N): inputs req[N] and ptr; outputs one-hot gnt[N], gnt_idx, any.
//     Purely combinational; its unit is reused by future read-port sharing.
//   - Top level: picker + payload mux + rr_ptr register + write-stage registers + mask decode.
// TESTING
//   1 Reset: rst_n=0 with req_valid=4'b1111 -> req_ready=0, wr_enable=0, pending_mask=0.
//     Release rst_n -> req_ready=4'b0001 in the first cycle.
//   2 Round-robin: all 4 valid, each holding for one transfer -> grants in order 0,1,2,3,0.
//     wr_addr sequence matches; wr_enable is high for 5 consecutive cycles.
//   3 Zero reg: req0 writes addr=0, data=32'hFFFAAA -> wr_enable=0 and dropped_zero=1 for one cycle.
//     A subsequent regfile read of r0 returns 0.
//   4 Stall: req1 valid with addr=5, data=32'hFFF000 and wr_stall=1 for 3 cycles -> req_ready=0 throughout.
//     Drop stall -> ready the same cycle, wr_enable=1, pending_mask=32'h20 the next cycle.
//     Regfile r5 reads 32'hFFF000.
//   5 Mid-op reset: transfer to addr=7, then rst_n=0 before the next edge -> wr_enable falls asynchronously.
//     Regfile r7 keeps its old value.
//   6 Fairness: req0 held valid continuously while req2 pulses valid -> req2 is granted within 1 cycle.
//     req0 is never granted twice in a row while req2 waits.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write path.
//   REG_AW / REG_DW : address and data width of the 32x32 register file
//   NUM_REGS        : number of architectural registers
//   REG_ZERO        : index of the hard-wired zero register
package regfile_write_arbiter_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// rr_priority_picker: purely combinational round-robin picker.
//   req     in  N    request vector
//   ptr     in  PW   highest-priority index this cycle (always < N)
//   gnt     out N    one-hot grant, zero when no request
//   gnt_idx out PW   index of the granted request (0 when none)
//   any     out 1    at least one request is high
module rr_priority_picker
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  // Scan ptr, ptr+1, ... wrapping at N; the first hit wins. The sum is one
  // bit wider so the wrap works for N that is not a power of two.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      w_idx = w_sum[PW-1:0];
      if (!any && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// N requesters using round-robin arbitration and a one-cycle write stage.
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid[N]   requester i has a write pending
//   req_addr[N*AW] target register of requester i, slice [i*AW +: AW]
//   req_data[N*DW] write data of requester i, slice [i*DW +: DW]
//   req_ready[N]   one-hot grant; transfer = valid & ready at rising edge
//   wr_stall       blocks new grants this cycle
//   wr_enable/wr_addr/wr_data  register-file write port (staged)
//   pending_mask   one-hot of the register being written, zero when idle
//   dropped_zero   one-cycle pulse: an accepted write to r0 was discarded
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N*AW-1:0]     req_addr,
  input  logic [N*DW-1:0]     req_data,
  output logic [N-1:0]        req_ready,
  input  logic                wr_stall,
  output logic                wr_enable,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                dropped_zero
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic          r_wr_enable;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_dropped_zero;

  logic [N-1:0]  w_req;
  logic [N-1:0]  w_gnt;
  logic [PW-1:0] w_gnt_idx;
  logic          w_any;
  logic          w_xfer;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;
  logic [PW-1:0] w_ptr_next;

  // Stall and an asserted reset both suppress every grant, so no transfer
  // can be observed by a requester in those cycles.
  assign w_req = req_valid & {N{~wr_stall & rst_n}};

  rr_priority_picker #(.N(N), .PW(PW)) u_picker (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = w_any;

  // AND-OR payload mux driven by the one-hot grant.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
        w_sel_data = w_sel_data | req_data[i*DW +: DW];
      end
    end
  end

  // Pointer wraps at N, not at the next power of two.
  assign w_ptr_next = (w_gnt_idx == PW'(N-1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  // Write stage: one cycle after the transfer the register file sees the
  // write. Writes to r0 are loaded but not enabled, and flagged instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_enable    <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_dropped_zero <= 1'b0;
    end else if (w_xfer) begin
      r_wr_enable    <= (w_sel_addr != AW'(REG_ZERO));
      r_dropped_zero <= (w_sel_addr == AW'(REG_ZERO));
      r_wr_addr      <= w_sel_addr;
      r_wr_data      <= w_sel_data;
    end else begin
      r_wr_enable    <= 1'b0;
      r_dropped_zero <= 1'b0;
    end
  end

  assign wr_enable    = r_wr_enable;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign dropped_zero = r_dropped_zero;

  assign pending_mask = r_wr_enable ? (NUM_REGS'(1) << r_wr_addr) : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_stall;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [31:0]     pending_mask;
  logic            dropped_zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  regfile_write_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_stall     (wr_stall),
    .wr_enable    (wr_enable),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending_mask (pending_mask),
    .dropped_zero (dropped_zero)
  );

  always #5 clk = ~clk;

  // Reference register file: r0 is never written.
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(posedge clk) begin
    if (wr_enable && wr_addr != 5'd0) rf[wr_addr] <= wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    wr_stall = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(10 + i), 32'h1000_0000 + i);
    #1 rst_n = 1'b0;
    tick(); tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_enable got=%b exp=0", wr_enable); end
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask got=%h exp=0", pending_mask); end
    checks++; if (dropped_zero !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0) begin
      errors++; $display("FAIL reset_stage got dz=%b addr=%0d data=%h exp 0/0/0", dropped_zero, wr_addr, wr_data); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL release_ready got=%b exp=0001", req_ready); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_gnt); end
      tick();
      checks++; if (wr_enable !== 1'b1 || wr_addr !== 5'(10 + k % 4)) begin
        errors++; $display("FAIL rr_stage[%0d] got en=%b addr=%0d exp en=1 addr=%0d", k, wr_enable, wr_addr, 10 + k % 4); end
      checks++; if (pending_mask !== (32'h1 << (10 + k % 4))) begin
        errors++; $display("FAIL rr_mask[%0d] got=%h exp=%h", k, pending_mask, 32'h1 << (10 + k % 4)); end
      if (k == 4) req_valid = '0;
    end
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (wr_enable !== 1'b0 || wr_addr !== 5'd10) begin
      errors++; $display("FAIL rr_idle_stage got en=%b addr=%0d exp en=0 addr=10", wr_enable, wr_addr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rf[10 + i] !== 32'h1000_0000 + i) begin
        errors++; $display("FAIL rr_rf[%0d] got=%h exp=%h", 10 + i, rf[10 + i], 32'h1000_0000 + i); end
    end
  endtask

  task automatic test_zero_reg();
    // pointer is 1 here; only req0 is valid
    set_req(0, 1'b1, 5'd0, 32'hFFFAAA);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL zero_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (wr_enable !== 1'b0 || dropped_zero !== 1'b1) begin
      errors++; $display("FAIL zero_stage got en=%b dz=%b exp en=0 dz=1", wr_enable, dropped_zero); end
    checks++; if (wr_addr !== 5'd0 || wr_data !== 32'hFFFAAA || pending_mask !== 32'h0) begin
      errors++; $display("FAIL zero_load got addr=%0d data=%h mask=%h exp 0/00fffaaa/0", wr_addr, wr_data, pending_mask); end
    tick();
    checks++; if (dropped_zero !== 1'b0 || wr_data !== 32'hFFFAAA) begin
      errors++; $display("FAIL zero_after got dz=%b data=%h exp dz=0 data=00fffaaa", dropped_zero, wr_data); end
    checks++; if (rf[0] !== 32'h0) begin errors++; $display("FAIL zero_rf got=%h exp=0", rf[0]); end
  endtask

  task automatic test_stall();
    set_req(1, 1'b1, 5'd5, 32'hFFF000);
    wr_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, req_ready); end
      tick();
      checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL stall_en[%0d] got=%b exp=0", k, wr_enable); end
    end
    wr_stall = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL unstall_ready got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (wr_enable !== 1'b1 || pending_mask !== 32'h20 || wr_data !== 32'hFFF000) begin
      errors++; $display("FAIL unstall_stage got en=%b mask=%h data=%h exp 1/00000020/00fff000", wr_enable, pending_mask, wr_data); end
    // A stall raised now must not block the write already staged.
    wr_stall = 1'b1;
    tick();
    wr_stall = 1'b0;
    checks++; if (rf[5] !== 32'hFFF000) begin errors++; $display("FAIL stall_rf5 got=%h exp=00fff000", rf[5]); end
  endtask

  task automatic test_mid_reset();
    // pointer is 2: give r7 a known old value via req2
    set_req(2, 1'b1, 5'd7, 32'h0000_7777);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_pre_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rf[7] !== 32'h0000_7777) begin errors++; $display("FAIL mid_pre_rf7 got=%h exp=00007777", rf[7]); end
    set_req(3, 1'b1, 5'd7, 32'hDEAD_BEEF);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready got=%b exp=1000", req_ready); end
    tick();
    checks++; if (wr_enable !== 1'b1) begin errors++; $display("FAIL mid_staged got=%b exp=1", wr_enable); end
    set_req(3, 1'b1, 5'd7, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_enable !== 1'b0 || pending_mask !== 32'h0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_async got en=%b mask=%h ready=%b exp 0/0/0000", wr_enable, pending_mask, req_ready); end
    tick();
    checks++; if (rf[7] !== 32'h0000_7777) begin errors++; $display("FAIL mid_rf7 got=%h exp=00007777", rf[7]); end
    req_valid = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fairness();
    // pointer is 0 after reset
    set_req(0, 1'b1, 5'd20, 32'h2020_2020);
    set_req(2, 1'b0, 5'd22, 32'h2222_2222);
    for (int k = 0; k < 4; k++) begin
      req_valid[2] = (k % 2 == 1);
      #1;
      if (k % 2 == 1) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_ready[%0d] got=%b exp=0100", k, req_ready); end
      end else begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_ready[%0d] got=%b exp=0001", k, req_ready); end
      end
      tick();
      checks++; if (wr_addr !== ((k % 2 == 1) ? 5'd22 : 5'd20)) begin
        errors++; $display("FAIL fair_addr[%0d] got=%0d exp=%0d", k, wr_addr, (k % 2 == 1) ? 22 : 20); end
    end
    req_valid = '0;
    tick();
    checks++; if (rf[20] !== 32'h2020_2020 || rf[22] !== 32'h2222_2222) begin
      errors++; $display("FAIL fair_rf got r20=%h r22=%h exp 20202020/22222222", rf[20], rf[22]); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_zero_reg();
    test_stall();
    test_mid_reset();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
